// File: rtl/draw_arb_pkg.sv
// Shared types and sizing helpers for the framebuffer draw-port arbiter.
package draw_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int CLIP_CNT_W = 16;

  // Burst counter only needs to reach MAX_BURST-1; release happens on that transfer.
  function automatic int burst_cnt_w(input int max_burst);
    return (max_burst <= 2) ? 1 : $clog2(max_burst);
  endfunction

endpackage

// File: rtl/draw_arbiter_if.sv
// Producer-side pixel handshake plus the registered VGA draw port, grouped for the arbiter.
interface draw_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int COORD_W = 32,
  parameter int COLOR_W = 32
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ*COORD_W-1:0] req_x;
  logic [NUM_REQ*COORD_W-1:0] req_y;
  logic [NUM_REQ*COLOR_W-1:0] req_color;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       draw_stall;
  logic                       enable_draw;
  logic [COORD_W-1:0]         draw_x;
  logic [COORD_W-1:0]         draw_y;
  logic [COLOR_W-1:0]         draw_color;

  modport master (
    output req_valid, req_last, req_x, req_y, req_color, draw_stall,
    input  req_ready, enable_draw, draw_x, draw_y, draw_color
  );

  modport slave (
    input  req_valid, req_last, req_x, req_y, req_color, draw_stall,
    output req_ready, enable_draw, draw_x, draw_y, draw_color
  );
endinterface

// File: rtl/draw_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr (wrapping); no latency.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing the VGA draw port; pixel out 1 cycle after accept, draw_stall freezes all.
// Optional off-screen clipping with saturating clip counter when DRAW_ARB_CLIP_EN is defined.
module draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int COORD_W   = 32,
  parameter int COLOR_W   = 32,
  parameter int MAX_BURST = 16,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic                  clock,
  input  logic                  reset,
  draw_arbiter_if.slave         bus,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy,
  output logic [CLIP_CNT_W-1:0] clip_cnt
);

  localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = burst_cnt_w(MAX_BURST);

`ifdef DRAW_ARB_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic               en_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COLOR_W-1:0] color_q;

  logic               owner_vld, owner_last, xfer, clipped;
  logic [COORD_W-1:0] own_x, own_y;
  logic [COLOR_W-1:0] own_color;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign owner_vld  = bus.req_valid[owner_q];
  assign owner_last = bus.req_last[owner_q];
  assign own_x      = bus.req_x[int'(owner_q)*COORD_W +: COORD_W];
  assign own_y      = bus.req_y[int'(owner_q)*COORD_W +: COORD_W];
  assign own_color  = bus.req_color[int'(owner_q)*COLOR_W +: COLOR_W];

  assign xfer          = (state_q == ST_BURST) && !bus.draw_stall && owner_vld;
  assign bus.req_ready = (state_q == ST_BURST && !bus.draw_stall) ? grant_q : '0;
  assign clipped       = CLIP_ON && ((own_x >= COORD_W'(SCREEN_W)) || (own_y >= COORD_W'(SCREEN_H)));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BURST;
          owner_d = pick_idx;
          grant_d = pick_gnt;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (!bus.draw_stall) begin
          if (xfer) cnt_d = cnt_q + 1'b1;
          // An owner dropping valid gives the port up immediately.
          if (!owner_vld ||
              (xfer && (owner_last || cnt_q == CNT_W'(MAX_BURST - 1)))) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      en_q    <= xfer && !clipped;
      if (xfer) begin
        x_q     <= own_x;
        y_q     <= own_y;
        color_q <= own_color;
      end
    end
  end

`ifdef DRAW_ARB_CLIP_EN
  logic [CLIP_CNT_W-1:0] clip_q;
  always_ff @(posedge clock) begin
    if (reset)                            clip_q <= '0;
    else if (xfer && clipped && !(&clip_q)) clip_q <= clip_q + 1'b1;
  end
  assign clip_cnt = clip_q;
`else
  assign clip_cnt = '0;
`endif

  assign bus.enable_draw = en_q;
  assign bus.draw_x      = x_q;
  assign bus.draw_y      = y_q;
  assign bus.draw_color  = color_q;
  assign grant           = grant_q;
  assign busy            = (state_q == ST_BURST);

endmodule

// File: tb/tb_draw_arbiter.sv
// Randomized scoreboard bench for draw_arbiter against a queue-based reference model.
module tb_draw_arbiter;
  localparam int N = 4, CW = 32, KW = 32, MAXB = 16, SW = 640, SH = 480;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  grant;
  logic          busy;
  logic [15:0]   clip_cnt;

  draw_arbiter_if #(.NUM_REQ(N), .COORD_W(CW), .COLOR_W(KW)) bus ();

  draw_arbiter #(
    .NUM_REQ(N), .COORD_W(CW), .COLOR_W(KW), .MAX_BURST(MAXB),
    .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .grant    (grant),
    .busy     (busy),
    .clip_cnt (clip_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] c;
    bit          last;
  } px_t;

  px_t rq[N][$];
  px_t exp_q[$];
  bit  vld[N];
  int  vld_pct = 100, stall_pct = 0;
  bit  force_stall = 1'b0;
  int  m_owner = -1, m_cnt = 0, m_ptr = 0, m_clip = 0;
  int  checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] one;
    one = 1;
    return (o < 0) ? '0 : (one << o);
  endfunction

  function automatic bit off_screen(input px_t p);
`ifdef DRAW_ARB_CLIP_EN
    return (p.x >= SW) || (p.y >= SH);
`else
    return 1'b0;
`endif
  endfunction

  task automatic add_px(input int r, input int n, input int last_every);
    px_t p;
    for (int k = 0; k < n; k++) begin
      p.x    = $urandom_range(700);
      p.y    = $urandom_range(520);
      p.c    = $urandom;
      p.last = (last_every > 0) && (((k + 1) % last_every) == 0);
      rq[r].push_back(p);
    end
  endtask

  task automatic add_one(input int r, input int x, input int y, input bit last);
    px_t p;
    p.x = x; p.y = y; p.c = $urandom; p.last = last;
    rq[r].push_back(p);
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step(input bit rst);
    bit  stall;
    px_t p;
    int  o, j;
    chk("grant", grant, onehot(m_owner));
    chk("busy", busy, m_owner >= 0);
    chk("clip_cnt", clip_cnt, m_clip);
    stall = force_stall || ($urandom_range(99) < stall_pct);
    for (int i = 0; i < N; i++) begin
      if (!vld[i] && rq[i].size() > 0 && $urandom_range(99) < vld_pct) vld[i] = 1'b1;
      bus.req_valid[i] = vld[i];
      if (vld[i]) begin
        p = rq[i][0];
        bus.req_x[i*CW +: CW]     = p.x;
        bus.req_y[i*CW +: CW]     = p.y;
        bus.req_color[i*KW +: KW] = p.c;
        bus.req_last[i]           = p.last;
      end
    end
    bus.draw_stall = stall;
    reset = rst;
    #1;
    if (!rst) chk("req_ready", bus.req_ready, (m_owner >= 0 && !stall) ? onehot(m_owner) : '0);
    o = m_owner;
    if (o < 0) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (m_owner < 0 && vld[j]) begin
          m_owner = j;
          m_cnt   = 0;
        end
      end
    end else if (!stall) begin
      if (vld[o]) begin
        p = rq[o].pop_front();
        vld[o] = 1'b0;
        m_cnt++;
        if (!rst) begin
          if (off_screen(p)) begin
            if (m_clip < 65535) m_clip++;
          end else exp_q.push_back(p);
        end
        if (p.last || m_cnt == MAXB) begin
          m_ptr = (o + 1) % N;
          m_owner = -1;
        end
      end else begin
        m_ptr = (o + 1) % N;
        m_owner = -1;
      end
    end
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_clip = 0;
    end
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  function automatic bit pending();
    bit any;
    any = (m_owner >= 0);
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) any = 1'b1;
    return any;
  endfunction

  task automatic drain();
    int g;
    g = 0;
    while (pending() && g < 4000) begin
      step(1'b0);
      g++;
    end
    checks++;
    if (g >= 4000) begin
      errors++;
      $display("FAIL drain: traffic still pending after %0d cycles", g);
    end
  endtask

  // Monitor: every strobe must match the oldest expected pixel.
  always @(negedge clock) begin
    px_t e;
    if (bus.enable_draw === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe: unexpected enable_draw x=%0d y=%0d at %0t", bus.draw_x, bus.draw_y, $time);
      end else begin
        e = exp_q.pop_front();
        chk("draw_x", bus.draw_x, e.x);
        chk("draw_y", bus.draw_y, e.y);
        chk("draw_color", bus.draw_color, e.c);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.req_valid = '0; bus.req_last = '0; bus.req_x = '0; bus.req_y = '0;
    bus.req_color = '0; bus.draw_stall = 1'b0; reset = 1'b1;
    for (int i = 0; i < N; i++) vld[i] = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst grant", grant, '0);
    chk("rst busy", busy, 0);
    chk("rst enable_draw", bus.enable_draw, 0);
    chk("rst draw_x", bus.draw_x, 0);
    chk("rst draw_y", bus.draw_y, 0);
    chk("rst draw_color", bus.draw_color, 0);
    chk("rst req_ready", bus.req_ready, '0);
    step(1'b1);

    // single requester, 3 pixels with last on the third
    add_px(1, 3, 3);
    drain();
    run(2);

    // fairness: everyone valid, 2-pixel bursts
    for (int r = 0; r < N; r++) add_px(r, 8, 2);
    drain();

    // burst cap: req0 streams without last, req2 arrives once req0 owns the port
    add_px(0, 40, 0);
    run(2);
    add_px(2, 6, 0);
    drain();

    // stall for 5 cycles mid-burst
    add_px(0, 10, 0);
    run(4);
    force_stall = 1'b1;
    run(5);
    force_stall = 1'b0;
    drain();

    // reset while req3 offers its 4th pixel
    for (int r = 0; r < N; r++) add_px(r, 8, 0);
    g = 0;
    while (!(m_owner == 3 && m_cnt == 3) && g < 500) begin
      step(1'b0);
      g++;
    end
    checks++;
    if (g >= 500) begin
      errors++;
      $display("FAIL reset_setup: req3 never reached its 4th pixel");
    end
    step(1'b1);
    drain();

    // on/off-screen boundary pixels
    add_one(1, 639, 479, 1'b0);
    add_one(1, 640, 10, 1'b1);
    drain();

    // randomized traffic with gaps and stalls
    for (int round = 0; round < 20; round++) begin
      vld_pct   = $urandom_range(30, 100);
      stall_pct = $urandom_range(0, 30);
      for (int r = 0; r < N; r++) add_px(r, $urandom_range(0, 20), $urandom_range(0, 5));
      drain();
    end
    stall_pct = 0;
    run(3);
    chk("exp_q empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
